// File: rtl/tpu_pkg.sv
// Shared opcode/state encodings and status bit positions for the TPU host loader.
package tpu_pkg;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_LOAD_W   = 3'd1,
        OP_LOAD_INP = 3'd2,
        OP_LOAD_INS = 3'd3,
        OP_START    = 3'd4,
        OP_ABORT    = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    localparam int ST_LOADING = 0;
    localparam int ST_RUNNING = 1;
    localparam int ST_DONE    = 2;
    localparam int ST_ERR     = 3;

    // START and ABORT always take precedence over a LOAD with the same code
    function automatic logic is_load_op(input logic [2:0] op, input int n_targets);
        return (op != OP_NOP) && (op != OP_START) && (op != OP_ABORT) &&
               (int'(op) <= n_targets);
    endfunction

endpackage

// File: rtl/tpu_addr_counter.sv
// Burst address generator: loadable wrap-around address counter plus a
// remaining-bytes down-counter whose last flag marks the final byte.
module tpu_addr_counter #(
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              en,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] addr_r;
    logic [LEN_W-1:0]  rem_r;

    // Address and remaining-count registers; address wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r <= {ADDR_W{1'b0}};
            rem_r  <= {LEN_W{1'b0}};
        end else if (load) begin
            addr_r <= base;
            rem_r  <= len;
        end else if (en) begin
            addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            rem_r  <= rem_r - {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
            addr_r <= addr_r;
            rem_r  <= rem_r;
        end
    end

    assign addr = addr_r;
    assign last = (rem_r == {LEN_W{1'b0}});

endmodule

// File: rtl/tpu_host_loader.sv
// Host command front end: decodes control-pin opcodes, streams burst writes
// into the target memories, pulses the core start and tracks run status.
module tpu_host_loader
    import tpu_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int N_TARGETS = 3,
    parameter int LEN_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    ui_in,
    input  logic [7:0]           uio_in,
    input  logic                 core_done,
    output logic [N_TARGETS-1:0] wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 start,
    output logic [3:0]           status,
    output logic [7:0]           uio_oe
);

    state_e                state_r, state_next_s;
    logic [2:0]            op_s;
    logic                  valid_s, load_op_s;
    logic [N_TARGETS-1:0]  tgt_oh_s, tgt_r;
    logic                  cnt_load_s, accept_s, cnt_last_s;
    logic [ADDR_W-1:0]     cnt_addr_s;
    logic                  err_next_s, done_next_s, start_next_s;
    logic [N_TARGETS-1:0]  wr_en_r;
    logic [ADDR_W-1:0]     wr_addr_r;
    logic [DATA_W-1:0]     wr_data_r;
    logic                  start_r;
    logic [3:0]            status_r;

    assign op_s      = uio_in[7:5];
    assign valid_s   = uio_in[4];
    assign load_op_s = is_load_op(op_s, N_TARGETS);

    // One-hot target select decoded from a LOAD opcode
    always_comb begin
        tgt_oh_s = {N_TARGETS{1'b0}};
        for (int k = 0; k < N_TARGETS; k++) begin
            tgt_oh_s[k] = load_op_s && (op_s == 3'(k + 1));
        end
    end

    tpu_addr_counter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_counter (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load_s),
        .en    (accept_s),
        .base  (ui_in[ADDR_W-1:0]),
        .len   (uio_in[LEN_W-1:0]),
        .addr  (cnt_addr_s),
        .last  (cnt_last_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, sticky status and write-acceptance decode
    always_comb begin
        state_next_s = state_r;
        err_next_s   = status_r[ST_ERR];
        done_next_s  = status_r[ST_DONE];
        start_next_s = 1'b0;
        cnt_load_s   = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (op_s == OP_START) begin
                    state_next_s = S_RUN;
                    start_next_s = 1'b1;
                    done_next_s  = 1'b0;
                end else if (load_op_s) begin
                    state_next_s = S_LOAD;
                    cnt_load_s   = 1'b1;
                end else if (op_s == OP_ABORT) begin
                    err_next_s  = 1'b0;
                    done_next_s = 1'b0;
                end else if (op_s != OP_NOP) begin
                    err_next_s = 1'b1;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (op_s == OP_ABORT) begin
                    state_next_s = S_IDLE;
                    err_next_s   = 1'b0;
                end else begin
                    if (op_s != OP_NOP) begin
                        err_next_s = 1'b1;
                    end else begin
                        err_next_s = status_r[ST_ERR];
                    end
                    // a stalled cycle neither writes nor advances the address
                    if (valid_s) begin
                        accept_s = 1'b1;
                        if (cnt_last_s) begin
                            state_next_s = S_IDLE;
                        end else begin
                            state_next_s = S_LOAD;
                        end
                    end else begin
                        accept_s = 1'b0;
                    end
                end
            end
            S_RUN: begin
                // ABORT beats a simultaneous core_done, so done stays clear
                if (op_s == OP_ABORT) begin
                    state_next_s = S_IDLE;
                    err_next_s   = 1'b0;
                end else begin
                    if (op_s != OP_NOP) begin
                        err_next_s = 1'b1;
                    end else begin
                        err_next_s = status_r[ST_ERR];
                    end
                    if (core_done) begin
                        state_next_s = S_IDLE;
                        done_next_s  = 1'b1;
                    end else begin
                        state_next_s = S_RUN;
                    end
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Target latched at the LOAD command for the whole burst
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tgt_r <= {N_TARGETS{1'b0}};
        end else if (cnt_load_s) begin
            tgt_r <= tgt_oh_s;
        end else begin
            tgt_r <= tgt_r;
        end
    end

    // Registered outputs: write port, start pulse and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en_r   <= {N_TARGETS{1'b0}};
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= {DATA_W{1'b0}};
            start_r   <= 1'b0;
            status_r  <= 4'b0000;
        end else begin
            wr_en_r <= accept_s ? tgt_r : {N_TARGETS{1'b0}};
            if (accept_s) begin
                wr_addr_r <= cnt_addr_s;
                wr_data_r <= ui_in;
            end
            start_r              <= start_next_s;
            status_r[ST_ERR]     <= err_next_s;
            status_r[ST_DONE]    <= done_next_s;
            status_r[ST_RUNNING] <= (state_next_s == S_RUN);
            status_r[ST_LOADING] <= (state_next_s == S_LOAD);
        end
    end

    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;
    assign start   = start_r;
    assign status  = status_r;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tpu_host_loader.sv
// Self-checking bench for tpu_host_loader: directed scenarios plus a random
// command stream compared cycle by cycle against a behavioural model.
module tb_tpu_host_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic       core_done = 1'b0;
    logic [2:0] wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic [3:0] status;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    // behavioural model: mode 0 idle, 1 loading, 2 running
    int         m_mode, m_tgt, m_addr, m_left;
    logic       m_err, m_done;
    logic [2:0] e_wr_en;
    logic [3:0] e_addr;
    logic [7:0] e_data;
    logic       e_start;
    logic [3:0] e_status;

    tpu_host_loader dut (
        .clk(clk), .reset(reset), .ui_in(ui_in), .uio_in(uio_in),
        .core_done(core_done), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .status(status), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 0; m_tgt = 0; m_addr = 0; m_left = 0;
        m_err = 1'b0; m_done = 1'b0;
        e_wr_en = 3'b000; e_addr = 4'h0; e_data = 8'h00; e_start = 1'b0;
        e_status = 4'b0000;
    endtask

    // drive one command cycle, advance the model, sample 1ns after the edge
    task automatic tick(input logic [2:0] op, input logic vld, input logic [3:0] len,
                        input logic [7:0] d);
        uio_in = {op, vld, len};
        ui_in  = d;
        e_wr_en = 3'b000;
        e_start = 1'b0;
        if (m_mode == 0) begin
            if (op == 3'd4) begin
                m_mode = 2; e_start = 1'b1; m_done = 1'b0;
            end else if (op >= 3'd1 && op <= 3'd3) begin
                m_mode = 1; m_tgt = int'(op) - 1; m_addr = int'(d) % 16;
                m_left = int'(len) + 1;
            end else if (op == 3'd7) begin
                m_err = 1'b0; m_done = 1'b0;
            end else if (op != 3'd0) begin
                m_err = 1'b1;
            end
        end else if (m_mode == 1) begin
            if (op == 3'd7) begin
                m_mode = 0; m_err = 1'b0;
            end else begin
                if (op != 3'd0) m_err = 1'b1;
                if (vld) begin
                    e_wr_en = 3'(1 << m_tgt);
                    e_addr  = 4'(m_addr);
                    e_data  = d;
                    m_addr  = (m_addr + 1) % 16;
                    m_left  = m_left - 1;
                    if (m_left == 0) m_mode = 0;
                end
            end
        end else begin
            if (op == 3'd7) begin
                m_mode = 0; m_err = 1'b0;
            end else begin
                if (op != 3'd0) m_err = 1'b1;
                if (core_done) begin
                    m_mode = 0; m_done = 1'b1;
                end
            end
        end
        e_status = {m_err, m_done, m_mode == 2, m_mode == 1};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (wr_en !== 3'b000) begin errors++; $display("FAIL reset_wr_en got %b want 000", wr_en); end
        checks++; if (wr_addr !== 4'h0) begin errors++; $display("FAIL reset_wr_addr got %h want 0", wr_addr); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", start); end
        checks++; if (status !== 4'b0000) begin errors++; $display("FAIL reset_status got %b want 0000", status); end
        checks++; if (uio_oe !== 8'h00) begin errors++; $display("FAIL uio_oe got %h want 00", uio_oe); end
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic test_burst_inputs();
        logic [7:0] bytes [4];
        bytes[0] = 8'hA1; bytes[1] = 8'hA2; bytes[2] = 8'hA3; bytes[3] = 8'hA4;
        tick(3'd2, 1'b0, 4'd3, 8'd5);
        checks++; if (status !== 4'b0001 || wr_en !== 3'b000) begin errors++; $display("FAIL burst_cmd status %b wr_en %b want 0001 000", status, wr_en); end
        for (int i = 0; i < 4; i++) begin
            tick(3'd0, 1'b1, 4'd0, bytes[i]);
            checks++;
            if (wr_en !== 3'b010 || wr_addr !== 4'(5 + i) || wr_data !== bytes[i]) begin
                errors++;
                $display("FAIL burst_write%0d got en %b addr %0d data %h want 010 %0d %h", i, wr_en, wr_addr, wr_data, 5 + i, bytes[i]);
            end
        end
        checks++; if (status !== 4'b0000) begin errors++; $display("FAIL burst_idle status got %b want 0000", status); end
        tick(3'd0, 1'b1, 4'd0, 8'h55);
        checks++; if (wr_en !== 3'b000) begin errors++; $display("FAIL burst_after got wr_en %b want 000", wr_en); end
    endtask

    task automatic test_stall_wrap();
        int want_addr [3];
        logic [7:0] b;
        want_addr[0] = 14; want_addr[1] = 15; want_addr[2] = 0;
        tick(3'd1, 1'b0, 4'd2, 8'hEE);
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s < 1 + i; s++) begin
                tick(3'd0, 1'b0, 4'd0, 8'($urandom));
                checks++; if (wr_en !== 3'b000) begin errors++; $display("FAIL stall_no_write got %b want 000", wr_en); end
            end
            b = 8'($urandom);
            tick(3'd0, 1'b1, 4'd0, b);
            checks++;
            if (wr_en !== 3'b001 || wr_addr !== 4'(want_addr[i]) || wr_data !== b) begin
                errors++;
                $display("FAIL stall_write%0d got en %b addr %0d data %h want 001 %0d %h", i, wr_en, wr_addr, wr_data, want_addr[i], b);
            end
        end
        checks++; if (status[0] !== 1'b0) begin errors++; $display("FAIL stall_loading got %b want 0", status[0]); end
    endtask

    task automatic test_start_done();
        tick(3'd4, 1'b0, 4'd0, 8'h00);
        checks++; if (start !== 1'b1 || status !== 4'b0010) begin errors++; $display("FAIL start_pulse start %b status %b want 1 0010", start, status); end
        for (int i = 1; i < 10; i++) begin
            tick((i == 4) ? 3'd4 : 3'd0, 1'b0, 4'd0, 8'h00);
            checks++; if (start !== 1'b0 || status[1] !== 1'b1) begin errors++; $display("FAIL run_cycle%0d start %b running %b want 0 1", i, start, status[1]); end
        end
        checks++; if (status !== 4'b1010) begin errors++; $display("FAIL restart_err status got %b want 1010", status); end
        core_done = 1'b1;
        tick(3'd0, 1'b0, 4'd0, 8'h00);
        core_done = 1'b0;
        checks++; if (status !== 4'b1100) begin errors++; $display("FAIL done_status got %b want 1100", status); end
        tick(3'd7, 1'b0, 4'd0, 8'h00);
        checks++; if (status !== 4'b0000) begin errors++; $display("FAIL abort_clear got %b want 0000", status); end
    endtask

    task automatic test_reserved();
        tick(3'd5, 1'b0, 4'd0, 8'h00);
        checks++; if (status !== 4'b1000 || start !== 1'b0) begin errors++; $display("FAIL reserved_err status %b start %b want 1000 0", status, start); end
        tick(3'd0, 1'b0, 4'd0, 8'h00);
        checks++; if (status !== 4'b1000) begin errors++; $display("FAIL reserved_sticky got %b want 1000", status); end
        tick(3'd7, 1'b0, 4'd0, 8'h00);
        checks++; if (status !== 4'b0000) begin errors++; $display("FAIL reserved_abort got %b want 0000", status); end
    endtask

    task automatic test_abort_burst();
        tick(3'd3, 1'b0, 4'd2, 8'd3);
        tick(3'd0, 1'b1, 4'd0, 8'h31);
        checks++; if (wr_en !== 3'b100 || wr_addr !== 4'd3 || wr_data !== 8'h31) begin errors++; $display("FAIL abort_byte1 got %b %0d %h want 100 3 31", wr_en, wr_addr, wr_data); end
        tick(3'd7, 1'b1, 4'd0, 8'h32);
        checks++; if (wr_en !== 3'b000 || status !== 4'b0000) begin errors++; $display("FAIL abort_byte2 wr_en %b status %b want 000 0000", wr_en, status); end
        tick(3'd1, 1'b0, 4'd0, 8'd9);
        tick(3'd0, 1'b1, 4'd0, 8'h77);
        checks++; if (wr_en !== 3'b001 || wr_addr !== 4'd9 || wr_data !== 8'h77) begin errors++; $display("FAIL abort_reload got %b %0d %h want 001 9 77", wr_en, wr_addr, wr_data); end
        checks++; if (status !== 4'b0000) begin errors++; $display("FAIL abort_reload_idle got %b want 0000", status); end
    endtask

    task automatic test_reset_mid_load();
        tick(3'd2, 1'b0, 4'd3, 8'd0);
        tick(3'd0, 1'b1, 4'd0, 8'hB1);
        uio_in = 8'b000_1_0000;
        ui_in  = 8'hB2;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (wr_en !== 3'b000 || wr_addr !== 4'h0 || wr_data !== 8'h00 || start !== 1'b0 || status !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset got %b %h %h %b %b want all zero", wr_en, wr_addr, wr_data, start, status);
        end
        #2 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick(3'd0, 1'b1, 4'd0, 8'hB3 + 8'(i));
            checks++; if (wr_en !== 3'b000 || status !== 4'b0000) begin errors++; $display("FAIL post_reset%0d wr_en %b status %b want 000 0000", i, wr_en, status); end
        end
    endtask

    task automatic test_random();
        int r;
        logic [2:0] op;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      op = 3'd0;
            else if (r < 75) op = 3'($urandom_range(1, 3));
            else if (r < 85) op = 3'd4;
            else if (r < 93) op = 3'd7;
            else             op = 3'($urandom_range(5, 6));
            core_done = ($urandom_range(0, 7) == 0);
            tick(op, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom));
            checks++;
            if ({wr_en, wr_addr, wr_data, start, status} !== {e_wr_en, e_addr, e_data, e_start, e_status}) begin
                errors++;
                $display("FAIL random%0d got en %b addr %h data %h start %b status %b want %b %h %h %b %b",
                         n, wr_en, wr_addr, wr_data, start, status, e_wr_en, e_addr, e_data, e_start, e_status);
            end
            checks++; if ($countones(wr_en) > 1) begin errors++; $display("FAIL onehot%0d got %b want at most one bit", n, wr_en); end
        end
        core_done = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_burst_inputs();
        test_stall_wrap();
        test_start_done();
        test_reserved();
        test_abort_burst();
        test_reset_mid_load();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tpu_host_loader.md
Name: tpu_host_loader

Overview:
- Host-interface front end of the TPU; successor to the fixed one-hot flag decoder.
- Decodes host commands from the bidirectional control pins.
- Runs addressed burst writes of ui_in bytes into N_TARGETS on-chip memories (weights, inputs, instructions), issues the core start strobe and tracks run/done/error status.
- Sits between the tt_um top-level pins and the tpu core/memories.

Parameters:
- DATA_W, 8, width of data bytes on ui_in and wr_data.
- ADDR_W, 4, memory address width; addresses wrap mod 2^ADDR_W.
- N_TARGETS, 3, number of loadable memories; target k selected by opcode k+1.
- LEN_W, 4, burst length field width; a burst is 1..2^LEN_W bytes.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ui_in  in  DATA_W  command-cycle base address (low ADDR_W bits) / load-cycle data byte
- uio_in  in  8  [7:5] opcode, [4] data valid (LOAD only), [LEN_W-1:0] burst length minus 1 (IDLE only)
- core_done  in  1  level from core: program finished
- wr_en  out  N_TARGETS  one-hot memory write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  DATA_W  write data
- start  out  1  one-cycle core start pulse
- status  out  4  {err, done, running, loading}
- uio_oe  out  8  constant 8'h00 (all control pins inputs)

Behaviour:
- Reset (async, active-high):
  - state=IDLE; wr_en=0, wr_addr=0, wr_data=0, start=0, status=0.
  - Asserting reset mid-burst or mid-run aborts with no further writes.
- Opcodes:
  - 000 NOP.
  - 001..N_TARGETS LOAD target (opcode-1).
  - 100 START.
  - 111 ABORT/CLEAR.
  - Everything else reserved.
  - With N_TARGETS≥4, START is taken in preference to LOAD.
- IDLE:
  - LOAD: latch target, base=ui_in[ADDR_W-1:0], remaining=uio_in[LEN_W-1:0]; next LOAD; loading=1 from next cycle.
  - START: next RUN; start=1 for exactly the first RUN cycle; done cleared.
  - Reserved opcode: err<=1, stay IDLE.
  - ABORT: clear err and done.
- LOAD:
  - Each cycle with uio_in[4]=1 accepts ui_in.
  - Next cycle: wr_en[target]=1, wr_addr=current address, wr_data=byte. Registered; latency 1 cycle.
  - Address then increments, wrapping 2^ADDR_W-1 -> 0.
  - valid=0: no write, no advance (host stalls freely).
  - On acceptance of the byte with remaining==0: next state IDLE. The final write still appears the following cycle; loading drops the same cycle the final write appears.
  - Opcode 111 in LOAD: immediate IDLE, the byte on that cycle is not written, err cleared.
  - Other non-zero opcode in LOAD: ignored but err<=1; the valid bit is still honoured.
- RUN:
  - running=1.
  - core_done=1: next IDLE, done<=1 (sticky until next START or ABORT).
  - ABORT: IDLE, done stays 0.
  - Any other command in RUN: ignored, err<=1.
  - START while in RUN never re-pulses start.
- Simultaneous core_done and ABORT in RUN: ABORT wins, done stays 0.
- wr_en is never multi-hot; at most one strobe per cycle.
- Burst of 2^LEN_W with base near the top wraps and overwrites low addresses. This is intended; no error.

Decomposition:
- Package tpu_pkg:
  - opcode enum (OP_NOP, OP_LOAD_W, OP_LOAD_INP, OP_LOAD_INS, OP_START, OP_ABORT).
  - state enum (S_IDLE, S_LOAD, S_RUN).
  - status bit index constants.
- One natural sub-module: tpu_addr_counter. Loadable, enabled, wrap-around ADDR_W counter plus LEN_W down-counter with a last flag.

Test Plan:
- Reset mid-LOAD: assert reset during byte 2 of a 4-byte burst -> all outputs 0 immediately; no wr_en afterwards.
- Burst to inputs:
  - Stimulus: uio_in=8'b010_0_0011, ui_in=5, then bytes A1,A2,A3,A4 with valid.
  - Required: wr_en=3'b010 at addrs 5,6,7,8 with data A1..A4, each 1 cycle after its byte; IDLE after A4.
- Stall and wrap:
  - Stimulus: weights burst len 3, base 14; valid gaps between bytes.
  - Required: writes at 14,15,0 only on valid cycles; loading=0 after the third write.
- Start/done:
  - Stimulus: START; core_done after 10 cycles.
  - Required: start high exactly 1 cycle; running=1 for the run; status done=1 after core_done; a second START during RUN gives no pulse and err=1.
- Reserved opcode 101 in IDLE -> err=1; then ABORT -> err=0, state IDLE.
- ABORT mid-burst:
  - Stimulus: ABORT with valid=1 on byte 2 of 3.
  - Required: only byte 1 written; next command LOAD accepted normally.
